// File: rtl/bank_reader_pkg.sv
// Shared types and defaults for the input-bank streaming reader.
package bank_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/bank_rd_fifo.sv
// Small synchronous FIFO holding {last, data} beats between bank capture and the stream port.
module bank_rd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // On full push+pop the write lands on the slot being popped; the head is read before the edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && full && !pop)) else $error("bank_rd_fifo overflow");
  end

  assign pop_data = mem[rd_ptr];
  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;

endmodule

// File: rtl/bank_reader.sv
// Streaming read master: walks a wrapped address window of the input bank and presents bytes on a valid/ready stream.
module bank_reader
  import bank_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 1024,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  csen,
  output logic                  rdena,
  output logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] data_a,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  localparam int                CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);
  localparam logic [CW:0]       CREDIT_L = (CW+1)'(FIFO_DEPTH);

  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH:0]   len_q, issued, beats;
  logic                  rd_vld_p0, vld_p1, credit_ok, last_p1, pop;
  logic                  fifo_full, fifo_empty;
  logic [CW-1:0]         fifo_count;
  logic [DATA_WIDTH:0]   head;

  function automatic logic [ADDR_WIDTH-1:0] wrap_add(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [ADDR_WIDTH-1:0] b);
    logic [ADDR_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= DEPTH_L) s = s - DEPTH_L;
    return s[ADDR_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (length == '0) ? DONE : RUN;
      RUN:     if (rd_vld_p0 && (issued == len_q - ONE_L)) state_nx = DRAIN;
      DRAIN:   if (m_valid && m_ready && m_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  // p0: issue a read only when the FIFO can absorb it plus any read already in flight
  assign credit_ok = !fifo_full &&
                     (({1'b0, fifo_count} + {{CW{1'b0}}, vld_p1}) < CREDIT_L);
  assign rd_vld_p0 = (state == RUN) && (issued < len_q) && credit_ok;
  assign rdena     = rd_vld_p0;
  assign csen      = rd_vld_p0;
  assign addr_a    = rd_vld_p0 ? wrap_add(base_q, issued[ADDR_WIDTH-1:0]) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      len_q  <= '0;
      issued <= '0;
      beats  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_vld_p0;
      if (state == IDLE && start) begin
        base_q <= ADDR_WIDTH'({1'b0, base_addr} % DEPTH_L);
        len_q  <= length;
        issued <= '0;
        beats  <= '0;
      end else begin
        if (rd_vld_p0) issued <= issued + ONE_L;
        if (vld_p1)    beats  <= beats + ONE_L;
      end
    end
  end

  // p1: bank data arrives one cycle after the read; tag the final byte and buffer it
  assign last_p1 = (beats == len_q - ONE_L);

  bank_rd_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (vld_p1),
    .push_data ({last_p1, data_a}),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? head[DATA_WIDTH-1:0] : '0;
  assign m_last  = m_valid ? head[DATA_WIDTH] : 1'b0;

endmodule

// File: tb/tb_bank_reader.sv
// Directed bench for bank_reader: table of transfers plus stall, restart and reset sequences.
module tb_bank_reader;

  localparam int AW = 13;
  localparam int DW = 8;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst, start, busy, done, csen, rdena, m_valid, m_ready, m_last;
  logic [AW-1:0] base_addr, addr_a;
  logic [AW:0]   length;
  logic [DW-1:0] data_a, m_data;

  always #5 clk = ~clk;

  bank_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DATA_DEPTH (DEPTH),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .csen      (csen),
    .rdena     (rdena),
    .addr_a    (addr_a),
    .data_a    (data_a),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last)
  );

  // Bank preloaded with addr[7:0]; registered read port, zero when not reading.
  always @(posedge clk) data_a <= (rdena && csen) ? addr_a[7:0] : 8'h00;

  int tests = 0;
  int fails = 0;
  int q_d[$];
  int q_l[$];
  int q_a[$];
  int done_cyc, done_cnt, fv, rd_cnt, valid_cnt, max_out, csen_bad;

  typedef struct {
    int base; int len; int first; int last_b; int cnt; int fv; int dn;
  } vec_t;
  vec_t vecs[5];

  function automatic void chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endfunction

  function automatic int exp_addr(int base, int i);
    return ((base % DEPTH) + i) % DEPTH;
  endfunction

  task automatic run_xfer(input int base, input int len, input int stall_at,
                          input int stall_n, input int restart_at);
    int pops;
    q_d.delete(); q_l.delete(); q_a.delete();
    done_cyc = -1; done_cnt = 0; fv = -1; rd_cnt = 0; valid_cnt = 0;
    max_out = 0; csen_bad = 0; pops = 0;
    @(negedge clk);
    base_addr = AW'(base); length = (AW+1)'(len); start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 200; c++) begin
      m_ready = !(c >= stall_at && c < stall_at + stall_n);
      if (c == restart_at) begin
        start = 1'b1; base_addr = AW'(500); length = (AW+1)'(3);
      end else start = 1'b0;
      #1;
      if (csen !== rdena) csen_bad++;
      if (rdena) begin rd_cnt++; q_a.push_back(int'(addr_a)); end
      if (rd_cnt - pops > max_out) max_out = rd_cnt - pops;
      if (m_valid) begin valid_cnt++; if (fv < 0) fv = c; end
      if (m_valid && m_ready) begin
        q_d.push_back(int'(m_data)); q_l.push_back(int'(m_last)); pops++;
      end
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
      @(posedge clk); #1;
    end
    start = 1'b0; m_ready = 1'b1;
  endtask

  task automatic check_stream(input string nm, input int base, input int len);
    int bad_d, bad_a, lastsum;
    bad_d = 0; bad_a = 0; lastsum = 0;
    for (int i = 0; i < q_d.size(); i++) begin
      if (q_d[i] != (exp_addr(base, i) & 255)) bad_d++;
      lastsum += q_l[i];
    end
    for (int i = 0; i < q_a.size(); i++)
      if (q_a[i] != exp_addr(base, i)) bad_a++;
    chk({nm, "_count"}, q_d.size(), len);
    chk({nm, "_reads"}, rd_cnt, len);
    chk({nm, "_data_bad"}, bad_d, 0);
    chk({nm, "_addr_bad"}, bad_a, 0);
    chk({nm, "_csen_bad"}, csen_bad, 0);
    chk({nm, "_done_cnt"}, done_cnt, 1);
    if (len > 0) begin
      chk({nm, "_last_cnt"}, lastsum, 1);
      chk({nm, "_last_pos"}, q_l[q_l.size()-1], 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{base: 10,   len: 5, first: 10,  last_b: 14,  cnt: 5, fv: 3,  dn: 8};
    vecs[1] = '{base: 1022, len: 4, first: 254, last_b: 1,   cnt: 4, fv: 3,  dn: 7};
    vecs[2] = '{base: 0,    len: 0, first: 0,   last_b: 0,   cnt: 0, fv: -1, dn: 1};
    vecs[3] = '{base: 2000, len: 3, first: 208, last_b: 210, cnt: 3, fv: 3,  dn: 6};
    vecs[4] = '{base: 5,    len: 1, first: 5,   last_b: 5,   cnt: 1, fv: 3,  dn: 4};

    rst = 1'b1; start = 1'b0; m_ready = 1'b0; base_addr = '0; length = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rdena", int'(rdena), 0);
    chk("rst_csen", int'(csen), 0);
    chk("rst_addr", int'(addr_a), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_last", int'(m_last), 0);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_xfer(vecs[v].base, vecs[v].len, 0, 0, -1);
      check_stream($sformatf("vec%0d", v), vecs[v].base, vecs[v].cnt);
      chk($sformatf("vec%0d_first_valid", v), fv, vecs[v].fv);
      chk($sformatf("vec%0d_done_cyc", v), done_cyc, vecs[v].dn);
      if (vecs[v].cnt > 0) begin
        chk($sformatf("vec%0d_first", v), q_d[0], vecs[v].first);
        chk($sformatf("vec%0d_lastbyte", v), q_d[q_d.size()-1], vecs[v].last_b);
      end else begin
        chk($sformatf("vec%0d_valid_seen", v), valid_cnt, 0);
      end
    end

    // Consumer stalls for 10 cycles after the first beat.
    run_xfer(100, 16, 4, 10, -1);
    check_stream("stall", 100, 16);
    chk("stall_max_buffered", max_out, 4);
    chk("stall_done_cyc", done_cyc, 29);

    // Second start mid-transfer is dropped.
    run_xfer(10, 5, 0, 0, 4);
    check_stream("restart", 10, 5);
    chk("restart_done_cyc", done_cyc, 8);

    // Reset while the FIFO holds data.
    @(negedge clk);
    base_addr = AW'(50); length = (AW+1)'(8); start = 1'b1; m_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_valid", int'(m_valid), 1);
    chk("pre_rst_data", int'(m_data), 50);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_rdena", int'(rdena), 0);
    chk("mid_rst_csen", int'(csen), 0);
    chk("mid_rst_addr", int'(addr_a), 0);
    chk("mid_rst_valid", int'(m_valid), 0);
    chk("mid_rst_data", int'(m_data), 0);
    chk("mid_rst_last", int'(m_last), 0);
    rst = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    run_xfer(200, 3, 0, 0, -1);
    check_stream("post_rst", 200, 3);
    chk("post_rst_first", q_d.size() > 0 ? q_d[0] : -1, 200);
    chk("post_rst_done_cyc", done_cyc, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bank_reader.md
# bank_reader

Streaming read master for the on-chip SPI-loaded input memory bank. On a `start` command it walks a contiguous address window of the bank through its registered read port, absorbing the bank's one-cycle read latency. Read bytes are buffered in a small FIFO and presented on a valid/ready stream to the accelerator datapath, with a `last` marker on the final byte. It sits between the bank's read port (`addr_a`/`rdena`/`data_a`, gated by `csen`) and the compute engine's input stream.

## Interface
- `ADDR_WIDTH`, 13, bank address width.
- `DATA_WIDTH`, 8, bank/stream data width.
- `DATA_DEPTH`, 1024, number of valid bank words; addresses wrap modulo this value.
- `FIFO_DEPTH`, 4, output buffer entries; power of two, ≥2.

Ports:
- `clk` input 1: the single clock; all logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: one-cycle command pulse; ignored while `busy`.
- `base_addr` input ADDR_WIDTH: first address; sampled on accepted `start`.
- `length` input ADDR_WIDTH+1: byte count, 0..DATA_DEPTH; sampled on accepted `start`.
- `busy` output 1: transfer in progress.
- `done` output 1: one-cycle completion pulse.
- `csen` output 1: bank chip select.
- `rdena` output 1: bank read enable.
- `addr_a` output ADDR_WIDTH: bank read address.
- `data_a` input DATA_WIDTH: bank read data, valid the cycle after `rdena`&`csen`, zero otherwise.
- `m_valid` output 1: stream data valid.
- `m_ready` input 1: stream consumer ready.
- `m_data` output DATA_WIDTH: stream byte.
- `m_last` output 1: marks the final byte of the transfer.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE, `start`=1, `length`≠0: latch the base address and length, clear the issue and beat counters, go to RUN.
- IDLE, `start`=1, `length`=0: go to DONE; no bank reads are issued.
- RUN: issue one read per cycle while `issued < length` and `fifo_count + inflight < FIFO_DEPTH`.
  - `inflight` is 0 or 1 and equals the previous cycle's `rdena`.
  - Once the last read is issued, go to DRAIN.
- DRAIN: wait until the final beat handshakes (`m_valid & m_ready & m_last`), then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `busy`=1 in RUN and DRAIN; `busy`=0 in IDLE and DONE.
- `csen` = `rdena`; both are low whenever no read is issued.
- Addressing: `addr_a` = `base_addr` + `issued`, wrapping to 0 after DATA_DEPTH−1. Compute the sum in ADDR_WIDTH+1 bits and subtract DATA_DEPTH on overflow. A `base_addr` ≥ DATA_DEPTH is reduced modulo DATA_DEPTH at latch time.
- Capture: the cycle after `rdena`, `data_a` is pushed into the FIFO together with a last flag (set when it is byte number `length`−1). The credit rule guarantees the FIFO never overflows; an overflow is a simulation assertion failure.
- Stream: `m_valid` = FIFO not empty; `m_data`/`m_last` come from the FIFO head. Data is held stable while `m_valid & !m_ready`.
- Simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- `start` arriving while `busy` or in DONE is dropped silently.
- `rst` in any state: the FSM returns to IDLE and the FIFO is flushed; in-flight read data is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `csen`=0, `rdena`=0, `addr_a`=0, `m_valid`=0, `m_data`=0, `m_last`=0.
- Cycle 0 is the edge at which `start` is sampled.
  - Cycle 1: first `rdena` with `addr_a`=`base_addr`.
  - Cycle 2: `data_a` valid.
  - Cycle 3: first `m_valid`.
- Start-to-first-byte latency: 3 cycles.
- With `m_ready` held high, throughput is 1 byte per cycle and the last `m_valid` falls at cycle `length`+2. `done` pulses the cycle after the last handshake.
- For `length`=0, `done` pulses at cycle 1.
- After `m_ready` has been low, reads resume in the cycle after a FIFO slot frees. There are no bubbles beyond the credit limit.

## Structure
- Package `bank_reader_pkg`: FSM state enum (IDLE, RUN, DRAIN, DONE) and the default FIFO_DEPTH constant.
- Sub-module `bank_rd_fifo`: synchronous FIFO of width DATA_WIDTH+1 (data plus last flag). It provides push/pop and full/empty, has a registered count, and flushes on `rst`.
- `bank_reader` contains the FSM, counters, address wrap and credit logic.

## Test plan
- Bank preloaded with addr[7:0]; `base_addr`=10, `length`=5, `m_ready`=1 → `m_data` reads 10,11,12,13,14 on cycles 3–7; `m_last` on 14; `done` at cycle 8.
- `base_addr`=1022, `length`=4 → `addr_a` sequence 1022,1023,0,1; stream bytes match those addresses.
- `length`=0 → `done` at cycle 1; `rdena` never asserts; `m_valid` stays 0.
- `length`=16 with `m_ready` low for 10 cycles after the first beat → at most FIFO_DEPTH bytes are buffered; no data is lost or reordered; `data_a` is never dropped.
- `start` pulsed again mid-transfer → ignored; exactly one `done`; the byte count equals the first `length`.
- `rst` asserted during RUN with the FIFO non-empty → next cycle all outputs are at reset values; a new `start` streams correctly from its own `base_addr`.
